// File: rtl/sprite_blit_scheduler.sv
// rtl/sprite_blit_scheduler.sv - round-robin sprite ROM arbiter and back-buffer blitter
module sprite_blit_scheduler #(
    parameter int         NUM_REQ     = 4,
    parameter int         SPR_W       = 24,
    parameter int         SPR_H       = 45,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter logic [4:0] TRANSPARENT = 5'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  frame_start_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*10-1:0] pos_x_i,
    input  logic [NUM_REQ*10-1:0] pos_y_i,
    input  logic [NUM_REQ*12-1:0] sprite_base_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [11:0]           rom_addr_o,
    input  logic [4:0]            rom_data_i,
    output logic                  fb_we_o,
    output logic [18:0]           fb_addr_o,
    output logic [4:0]            fb_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CX_W  = $clog2(SPR_W + 1);
    localparam int CY_W  = $clog2(SPR_H + 1);
    localparam int OFF_W = $clog2(SPR_W * SPR_H + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] served_q, served_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [9:0]         px_q, px_d, py_q, py_d;
    logic [11:0]        base_q, base_d;
    logic [CX_W-1:0]    cx_q, cx_d;
    logic [CY_W-1:0]    cy_q, cy_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               drain_q, drain_d;
    logic               s1_valid_q, s1_valid_d;
    logic [10:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic               fb_we_q, fb_we_d;
    logic [18:0]        fb_addr_q, fb_addr_d;
    logic [4:0]         fb_data_q, fb_data_d;

    logic [NUM_REQ-1:0] cand;
    logic [PTR_W-1:0]   pick;
    logic               found;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
    endfunction

    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        px_d       = px_q;
        py_d       = py_q;
        base_d     = base_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        off_d      = off_q;
        drain_d    = drain_q;

        // Search starts at the pointer so the last-served requester goes to the back.
        cand  = req_i & ~served_q;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand[wrap_idx(int'(ptr_q) + i)]) begin
                found = 1'b1;
                pick  = wrap_idx(int'(ptr_q) + i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d  = S_ARB;
                    served_d = '0;
                end
            end
            S_ARB: begin
                if (found) begin
                    grant_d = pick;
                    px_d    = pos_x_i[10*int'(pick) +: 10];
                    py_d    = pos_y_i[10*int'(pick) +: 10];
                    base_d  = sprite_base_i[12*int'(pick) +: 12];
                    cx_d    = '0;
                    cy_d    = '0;
                    off_d   = '0;
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                off_d = off_q + 1'b1;
                if (cx_q == CX_W'(SPR_W - 1)) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                    if (cy_q == CY_W'(SPR_H - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_ACK;
            end
            S_ACK: begin
                served_d[grant_q] = 1'b1;
                ptr_d   = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = S_ARB;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Stage 1 travels alongside the ROM read; stage 2 qualifies and registers the write.
        s1_valid_d = (state_q == S_READ);
        s1_x_d     = {1'b0, px_q} + 11'(cx_q);
        s1_y_d     = {1'b0, py_q} + 11'(cy_q);
        fb_we_d    = s1_valid_q && (rom_data_i != TRANSPARENT) &&
                     (s1_x_q < 11'(SCREEN_W)) && (s1_y_q < 11'(SCREEN_H));
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        if (fb_we_d) begin
            fb_addr_d = 19'(s1_y_q) * 19'(SCREEN_W) + 19'(s1_x_q);
            fb_data_d = rom_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            served_q   <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            base_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            off_q      <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            px_q       <= px_d;
            py_q       <= py_d;
            base_q     <= base_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            off_q      <= off_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == S_ACK) ack_o[grant_q] = 1'b1;
    end

    // The linear pixel offset equals cy*SPR_W+cx, so no multiplier is needed on the ROM side.
    assign rom_addr_o   = base_q + 12'(off_q);
    assign fb_we_o      = fb_we_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);
endmodule

// File: tb/tb_sprite_blit_scheduler.sv
// tb/tb_sprite_blit_scheduler.sv - scoreboard bench with a pixel-level reference model
module tb_sprite_blit_scheduler;
    localparam int N = 4;

    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
    logic [3:0]  req = '0;
    logic [39:0] pos_x = '0, pos_y = '0;
    logic [47:0] sbase = '0;
    logic [3:0]  ack;
    logic [11:0] rom_addr;
    logic [4:0]  rom_data = '0;
    logic        fb_we, busy, frame_done;
    logic [18:0] fb_addr;
    logic [4:0]  fb_data;

    logic [4:0]  rom [4096];
    logic [23:0] exp_wr[$];
    int          exp_ack[$];
    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, wr_cnt = 0, last_ack = 0, mptr = 0;
    bit ack_seen = 0;
    int px[N], py[N], bs[N];

    sprite_blit_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .req_i(req),
        .pos_x_i(pos_x), .pos_y_i(pos_y), .sprite_base_i(sbase), .ack_o(ack),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .fb_we_o(fb_we),
        .fb_addr_o(fb_addr), .fb_data_o(fb_data), .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_we) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, none expected", fb_addr, fb_data);
                end else begin
                    logic [23:0] e;
                    e = exp_wr.pop_front();
                    chk("fb_addr", fb_addr, e[23:5]);
                    chk("fb_data", fb_data, e[4:0]);
                end
            end
            if (ack != 0) begin
                if (exp_ack.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    int g;
                    g = exp_ack.pop_front();
                    chk("ack_onehot", ack, 1 << g);
                end
                if (ack_seen) chk("ack_spacing", cyc - last_ack, 1084);
                ack_seen = 1;
                last_ack = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                chk("writes_pending_at_done", exp_wr.size(), 0);
                chk("acks_pending_at_done", exp_ack.size(), 0);
                if (ack_seen) chk("done_after_ack", cyc - last_ack, 2);
            end
        end
    end

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            pos_x[10*i +: 10] = 10'(px[i]);
            pos_y[10*i +: 10] = 10'(py[i]);
            sbase[12*i +: 12] = 12'(bs[i]);
        end
    endtask

    // Serve requesters round-robin from the model pointer, emitting every visible opaque pixel.
    task automatic model_pass(input logic [3:0] r, output int n);
        bit [3:0] served = '0;
        n = 0;
        for (int k = 0; k < N; k++) begin
            int g = -1;
            for (int i = 0; i < N; i++) begin
                int c = (mptr + i) % N;
                if (g < 0 && r[c] && !served[c]) g = c;
            end
            if (g < 0) break;
            served[g] = 1'b1;
            exp_ack.push_back(g);
            for (int y = 0; y < 45; y++)
                for (int x = 0; x < 24; x++) begin
                    int a  = (bs[g] + y * 24 + x) % 4096;
                    int sx = px[g] + x;
                    int sy = py[g] + y;
                    if (rom[a] != 5'd0 && sx < 640 && sy < 480) begin
                        exp_wr.push_back({19'(sy * 640 + sx), rom[a]});
                        n++;
                    end
                end
            mptr = (g + 1) % N;
        end
    endtask

    task automatic run_pass(input logic [3:0] r, input bit extra_fs, input bit disturb);
        int n, d0, w0;
        req = r;
        apply_inputs();
        model_pass(r, n);
        ack_seen = 0;
        d0 = done_cnt;
        w0 = wr_cnt;
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        if (extra_fs) begin
            tick(199);
            frame_start = 1'b1; tick(1); frame_start = 1'b0;
        end
        if (disturb) begin
            tick(100);
            req   = '0;
            pos_x = 40'({$urandom, $urandom});
            pos_y = 40'({$urandom, $urandom});
            sbase = 48'({$urandom, $urandom});
        end
        for (int i = 0; i < 6000 && done_cnt == d0; i++) tick(1);
        tick(4);
        chk("frame_done_count", done_cnt - d0, 1);
        chk("write_count", wr_cnt - w0, n);
    endtask

    task automatic set_req(input int i, input int x, input int y, input int b);
        px[i] = x; py[i] = y; bs[i] = b;
    endtask

    initial begin
        int n;
        for (int a = 0; a < 4096; a++) rom[a] = 5'h3;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
        apply_inputs();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("reset_fb_we", fb_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_ack", ack, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_fb_addr", fb_addr, 0);

        run_pass(4'b0001, 1'b1, 1'b0);

        for (int a = 0; a < 4096; a++) rom[a] = (a % 2 == 0) ? 5'd0 : 5'd9;
        run_pass(4'b0001, 1'b0, 1'b0);

        for (int a = 0; a < 4096; a++) rom[a] = 5'($urandom_range(31, 1));
        set_req(0, 630, 470, 0);
        run_pass(4'b0001, 1'b0, 1'b0);

        set_req(0, 10, 20, 0); set_req(1, 300, 200, 1080);
        set_req(2, 620, 5, 2160); set_req(3, 50, 440, 0);
        run_pass(4'b1111, 1'b0, 1'b0);
        run_pass(4'b1001, 1'b0, 1'b0);

        set_req(0, 100, 100, 7);
        run_pass(4'b0001, 1'b0, 1'b1);

        run_pass(4'b0000, 1'b0, 1'b0);

        set_req(1, 5, 5, 300);
        run_pass(4'b0010, 1'b0, 1'b0);

        set_req(2, 200, 150, 900);
        req = 4'b0100;
        apply_inputs();
        model_pass(req, n);
        ack_seen = 0;
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        tick(500);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fb_we", fb_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rom_addr", rom_addr, 0);
        chk("async_rst_ack", ack, 0);
        exp_wr.delete();
        exp_ack.delete();
        mptr = 0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        run_pass(4'b1111, 1'b0, 1'b0);

        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 4096; a++)
                rom[a] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1) == 1)
                    set_req(i, $urandom_range(639, 600), $urandom_range(479, 430), $urandom_range(4095));
                else
                    set_req(i, $urandom_range(1023), $urandom_range(1023), $urandom_range(4095));
            end
            run_pass(4'($urandom_range(15)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_blit_scheduler.md
Name: sprite_blit_scheduler

Overview:
- Shares the single sprite-ROM read port between NUM_REQ sprite requesters (player, enemies, bullets) and copies each granted sprite into the back frame buffer once per frame.
- Sits between the game-logic sprite registers and the dual frame buffer's write port.
- Runs after each buffer swap and arbitrates round-robin.
- Walks every sprite pixel, skips transparent pixels and clips pixels that fall off-screen.

Parameters:
NUM_REQ, 4, number of sprite requesters
SPR_W, 24, sprite width in pixels
SPR_H, 45, sprite height in pixels
SCREEN_W, 640, frame width in pixels
SCREEN_H, 480, frame height in pixels
TRANSPARENT, 5'h00, pixel code that is never written

Ports:
Clk  in  1  system clock, all logic on the rising edge
Reset  in  1  asynchronous, active-low reset
FrameStart  in  1  one-cycle pulse at buffer swap; starts a blit pass
Req  in  NUM_REQ  per-requester draw request, level, held until Ack
PosX  in  NUM_REQ*10  packed sprite top-left X, requester i at bits [10i+9:10i]
PosY  in  NUM_REQ*10  packed sprite top-left Y, same packing
SpriteBase  in  NUM_REQ*12  packed ROM base address of the requester's sprite image
Ack  out  NUM_REQ  one-cycle pulse when that requester's sprite is fully written
RomAddr  out  12  sprite-ROM read address (synchronous ROM, 1-cycle read latency)
RomData  in  5  encoded pixel returned by the ROM
FbWe  out  1  frame-buffer write enable
FbAddr  out  19  frame-buffer address, Y*SCREEN_W+X
FbData  out  5  encoded pixel to write
Busy  out  1  high from FrameStart acceptance until FrameDone
FrameDone  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE; served mask, round-robin pointer and counters clear to 0.
  - Ack, RomAddr, FbWe, FbAddr, FbData, Busy and FrameDone go to 0 immediately.
  - Any blit in flight is abandoned with no Ack.
- States:
  - IDLE: FrameStart=1 -> ARB, Busy=1, served mask cleared.
  - ARB (1 cycle): candidates are Req & ~served. Pick the first candidate at or after the pointer, with wrap-around. Latch that requester's PosX, PosY and SpriteBase; set cx=cy=0; go to READ. If there is no candidate, go to DONE.
  - READ: each cycle RomAddr=base+cy*SPR_W+cx. cx increments and wraps at SPR_W-1, which increments cy. After the address for cx=SPR_W-1, cy=SPR_H-1, go to DRAIN. READ lasts exactly SPR_W*SPR_H cycles (1080).
  - DRAIN (2 cycles): flush the pipeline, then go to ACK.
  - ACK (1 cycle): Ack[g]=1, served[g]=1, pointer=g+1 mod NUM_REQ, then go to ARB.
  - DONE (1 cycle): FrameDone=1, Busy=0 on exit, then go to IDLE.
- Pipeline:
  - The address issued in cycle k returns RomData in k+1.
  - FbWe, FbAddr and FbData are registered and valid in k+2.
  - FbWe=1 only if RomData!=TRANSPARENT and PosX+cx<SCREEN_W and PosY+cy<SCREEN_H.
  - Bound checks use 11-bit sums, so there is no wrap.
  - FbAddr=(PosY+cy)*SCREEN_W+(PosX+cx), computed at 19 bits. When FbWe=0, FbAddr and FbData hold their previous value.
- Cost per granted sprite: ARB+READ+DRAIN+ACK = 1084 cycles.
- Each requester is served at most once per pass. Req rising after it was served in this pass is ignored until the next FrameStart.
- Req deasserted mid-blit: the blit completes and Ack still pulses.
- Position/base inputs may change mid-blit; only the values latched in ARB are used.
- FrameStart while Busy=1 is ignored (no restart, no queuing).
- FrameStart in the same cycle as the DONE state is also ignored.
- The pointer persists across passes and is cleared only by reset.

Test Plan:
- Req=4'b0001, PosX0=0, PosY0=0, SpriteBase0=0, ROM all 5'h3, one FrameStart -> exactly 1080 FbWe pulses; first FbAddr=0, last FbAddr=28183; Ack[0] pulses once; FrameDone follows within 2 cycles of Ack.
- Same setup, ROM even addresses=0 -> 540 writes, none carrying FbData=0.
- PosX0=630, PosY0=470, ROM all nonzero -> writes only for cx 0..9, cy 0..9 = 100 writes; largest FbAddr=479*640+639=307199.
- Req=4'b1111, base 0/1080/2160/0 -> Acks in order 0,1,2,3, spaced 1084 cycles apart. Next pass with Req=4'b1001 -> grant order 0 then 3 (pointer wrapped to 0).
- Pulse Reset low 500 cycles into a blit -> FbWe=0, Busy=0 and RomAddr=0 asynchronously, and no Ack. After release plus FrameStart, the pass restarts from requester 0.
- FrameStart pulsed again 200 cycles into a pass -> ignored: same write count, a single FrameDone.
